wait_pulse_gen: RTL

- Parametrised successor to the fixed 16-bit wait counter.
- After `start` is asserted, generates a programmable train of equal-width high pulses on `out`, separated by equal low gaps, then either stops in a done state or repeats.
- Segment length and pulse count are runtime inputs; one-shot or repeat behaviour is a parameter.
- Sits between control logic and timed strobes such as settle delays, blink patterns and handshake timeouts.

---
 rtl/wait_pulse_gen.sv | 123 ++++++++++++
 1 files changed

// File: rtl/wait_pulse_gen.sv
// Programmable pulse-train generator: after start (active low) emits P high pulses of L cycles
// separated by L-cycle gaps, then stops in DONE (one-shot) or restarts (REPEAT=1).
module wait_pulse_gen #(
  parameter int WIDTH  = 16,
  parameter int PW     = 8,
  parameter bit REPEAT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seg_len,
  input  logic [PW-1:0]    pulses,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [PW-1:0]    pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] seg_cnt_r;
  logic [WIDTH-1:0] len_r;
  logic [PW:0]      seg_idx_r;
  logic [PW-1:0]    pul_r;

  logic [WIDTH-1:0] len_in_s;
  logic [PW-1:0]    pul_in_s;
  logic [WIDTH-1:0] len_m1_s;
  logic [PW:0]      last_idx_s;

  // Zero-length segments and zero pulse counts are promoted to one.
  assign len_in_s   = (seg_len == '0) ? WIDTH'(1) : seg_len;
  assign pul_in_s   = (pulses == '0) ? PW'(1) : pulses;
  assign len_m1_s   = len_r - WIDTH'(1);
  assign last_idx_s = {pul_r, 1'b0} - (PW + 1)'(1);

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      seg_cnt_r <= '0;
      seg_idx_r <= '0;
      len_r     <= WIDTH'(1);
      pul_r     <= PW'(1);
      out       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          out  <= 1'b0;
          done <= 1'b0;
          if (start == 1'b0) begin
            len_r     <= len_in_s;
            pul_r     <= pul_in_s;
            seg_cnt_r <= '0;
            seg_idx_r <= '0;
            pulse_cnt <= '0;
            busy      <= 1'b1;
            state_r   <= RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (start == 1'b1) begin
            // Abort takes priority over a segment boundary on the same edge.
            state_r   <= IDLE;
            out       <= 1'b0;
            busy      <= 1'b0;
            seg_cnt_r <= '0;
            seg_idx_r <= '0;
          end else if (seg_cnt_r != len_m1_s) begin
            seg_cnt_r <= seg_cnt_r + WIDTH'(1);
          end else begin
            seg_cnt_r <= '0;
            if (seg_idx_r[0] && (pulse_cnt != '1)) begin
              pulse_cnt <= pulse_cnt + PW'(1);
            end
            if (seg_idx_r != last_idx_s) begin
              seg_idx_r <= seg_idx_r + (PW + 1)'(1);
              out       <= ~seg_idx_r[0];
            end else begin
              out <= 1'b0;
              if (REPEAT) begin
                seg_idx_r <= '0;
              end else begin
                state_r <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          out  <= 1'b0;
          busy <= 1'b0;
          if (start == 1'b1) begin
            done    <= 1'b0;
            state_r <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          out       <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          seg_cnt_r <= '0;
          seg_idx_r <= '0;
        end
      endcase
    end
  end

endmodule
